// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-add multiplier controller.
package mult_pkg;

    localparam int MULT_WIDTH = 8;
    localparam int MULT_CNT_W = $clog2(MULT_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_ADD,
        S_SHIFT,
        S_HOLD
    } mult_state_t;

endpackage

// File: rtl/mult_iter_counter.sv
// Iteration counter for the multiplier sequencer; flags the final iteration.
module mult_iter_counter #(
    parameter int WIDTH = 8
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clear,
    input  logic increment,
    output logic last
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [CW-1:0] cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset || clear) begin
            cnt <= '0;
        end else if (increment) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign last = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/mult_ctrl.sv
// Sequencing controller for the 8-bit shift-add multiplier datapath.
// Define MULT_SIGNED_EN for two's-complement operation (final iteration subtracts).
module mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Run,
    input  logic ClearA_LoadB,
    input  logic M,
    output logic Clr_Ld,
    output logic Clear_AX,
    output logic Add_En,
    output logic Sub_En,
    output logic Shift_En,
    output logic Done,
    output logic Busy
);

    mult_state_t state_q, state_d;
    logic        cnt_clear;
    logic        cnt_incr;
    logic        cnt_last;
    logic        sub_iter;

    mult_iter_counter #(
        .WIDTH (WIDTH)
    ) u_iter_counter (
        .Clk       (Clk),
        .Reset     (Reset),
        .clear     (cnt_clear),
        .increment (cnt_incr),
        .last      (cnt_last)
    );

`ifdef MULT_SIGNED_EN
    // The sign-bit partial product carries negative weight, so it is subtracted.
    assign sub_iter = cnt_last;
`else
    assign sub_iter = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_clear = 1'b0;
        cnt_incr  = 1'b0;
        Clr_Ld    = 1'b0;
        Clear_AX  = 1'b0;
        Add_En    = 1'b0;
        Sub_En    = 1'b0;
        Shift_En  = 1'b0;
        Done      = 1'b0;
        Busy      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Run) begin
                    state_d = S_CLEAR;
                end else if (ClearA_LoadB) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                Clr_Ld = 1'b1;
                if (!ClearA_LoadB) begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                Clear_AX  = 1'b1;
                Busy      = 1'b1;
                cnt_clear = 1'b1;
                state_d   = S_ADD;
            end
            S_ADD: begin
                // Entered even when M=0 so every multiply has the same latency.
                Busy    = 1'b1;
                Add_En  = M & ~sub_iter;
                Sub_En  = M & sub_iter;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                Busy     = 1'b1;
                Shift_En = 1'b1;
                if (cnt_last) begin
                    state_d = S_HOLD;
                end else begin
                    cnt_incr = 1'b1;
                    state_d  = S_ADD;
                end
            end
            S_HOLD: begin
                // Wait for Run release so a held switch cannot retrigger.
                Done = 1'b1;
                if (!Run) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
